// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the mm:ss BCD countdown timer: FSM states, digit limits and preset clamping.
package bcd_countdown_timer_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] MAX_TENS  = 4'd5;
    localparam logic [BCD_W-1:0] MAX_UNITS = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    // Out-of-range BCD preset digits saturate to the digit's maximum.
    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d,
                                                     input logic [BCD_W-1:0] mx);
        return (d > mx) ? mx : d;
    endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with load and borrow-out; wraps 0 -> MAX on decrement.
module bcd_down_digit
    import bcd_countdown_timer_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = MAX_UNITS
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             dec,
    output logic [BCD_W-1:0] q,
    output logic             bout
);
    always_ff @(posedge CP) begin
        if (CR)
            q <= '0;
        else if (ld)
            q <= ld_val;
        else if (dec)
            q <= (q == '0) ? MAX : q - 1'b1;
    end

    assign bout = (q == '0) && dec;
endmodule

// File: rtl/bcd_countdown_timer.sv
// Presettable mm:ss BCD countdown timer; FSM, prescaler and clamping live here, digits in bcd_down_digit.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: reload the last preset on reaching 00:00 and keep running.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = 26
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       EN,
    input  logic       Load,
    input  logic [7:0] LdMin,
    input  logic [7:0] LdSec,
    output logic [3:0] MinH,
    output logic [3:0] MinL,
    output logic [3:0] SecH,
    output logic [3:0] SecL,
    output logic       Running,
    output logic       Done,
    output logic       Expired
);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t      state, state_nxt;
    logic [PRE_W-1:0] pre;
    logic [15:0] preset, ld_word;
    logic        tick, zero, at_one, hit_zero, reload, ld_any;
    logic        b_sl, b_sh, b_ml, b_mh;

    assign preset = {clamp_digit(LdMin[7:4], MAX_TENS), clamp_digit(LdMin[3:0], MAX_UNITS),
                     clamp_digit(LdSec[7:4], MAX_TENS), clamp_digit(LdSec[3:0], MAX_UNITS)};
    assign zero   = ({MinH, MinL, SecH, SecL} == 16'h0000);
    assign at_one = ({MinH, MinL, SecH, SecL} == 16'h0001);
    assign tick   = (state == S_RUN) && EN && (pre == PRE_LAST) && !Load && !reload;
    // A borrow out of the top digit could only mean the count was already 00:00.
    assign hit_zero = tick && (at_one || b_mh);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
    logic [15:0] shadow;

    always_ff @(posedge CP) begin
        if (CR)
            shadow <= '0;
        else if (Load)
            shadow <= preset;
    end

    // Reload happens on the edge after 00:00 is shown, so Done and 00:00 are visible together.
    assign reload  = (state == S_RUN) && zero && !Load;
    assign ld_word = Load ? preset : shadow;
`else
    localparam bit AUTO_RELOAD = 1'b0;
    assign reload  = 1'b0;
    assign ld_word = preset;
`endif

    assign ld_any = Load || reload;

    bcd_down_digit #(.MAX(MAX_UNITS)) u_sec_l (.CP(CP), .CR(CR), .ld(ld_any), .ld_val(ld_word[3:0]),
                                               .dec(tick), .q(SecL), .bout(b_sl));
    bcd_down_digit #(.MAX(MAX_TENS))  u_sec_h (.CP(CP), .CR(CR), .ld(ld_any), .ld_val(ld_word[7:4]),
                                               .dec(b_sl), .q(SecH), .bout(b_sh));
    bcd_down_digit #(.MAX(MAX_UNITS)) u_min_l (.CP(CP), .CR(CR), .ld(ld_any), .ld_val(ld_word[11:8]),
                                               .dec(b_sh), .q(MinL), .bout(b_ml));
    bcd_down_digit #(.MAX(MAX_TENS))  u_min_h (.CP(CP), .CR(CR), .ld(ld_any), .ld_val(ld_word[15:12]),
                                               .dec(b_ml), .q(MinH), .bout(b_mh));

    always_ff @(posedge CP) begin
        if (CR)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (Load) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (EN && !zero) state_nxt = S_RUN;
                S_RUN: begin
                    if (!EN)
                        state_nxt = S_PAUSE;
                    else if (hit_zero && !AUTO_RELOAD)
                        state_nxt = S_EXPIRED;
                end
                S_PAUSE:   if (EN) state_nxt = S_RUN;
                S_EXPIRED: state_nxt = S_EXPIRED;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Running = (state == S_RUN);
        Expired = (state == S_EXPIRED);
    end

    // Prescaler only advances while actually running; a pause keeps its phase.
    always_ff @(posedge CP) begin
        if (CR || ld_any)
            pre <= '0;
        else if (state == S_IDLE && state_nxt == S_RUN)
            pre <= '0;
        else if (state == S_RUN && EN)
            pre <= tick ? '0 : pre + 1'b1;
    end

    always_ff @(posedge CP) begin
        if (CR || Load)
            Done <= 1'b0;
        else
            Done <= hit_zero;
    end
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer (TICK_DIV=4): seconds-based reference model plus literal pins.
module tb_bcd_countdown_timer;
    localparam int TICK_DIV = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       CR = 1'b1, EN = 1'b0, Load = 1'b0;
    logic [7:0] LdMin = 8'h00, LdSec = 8'h00;
    logic [3:0] MinH, MinL, SecH, SecL;
    logic       Running, Done, Expired;

    bcd_countdown_timer #(.TICK_DIV(TICK_DIV), .PRE_W(3)) dut (
        .CP(clk), .CR(CR), .EN(EN), .Load(Load), .LdMin(LdMin), .LdSec(LdSec),
        .MinH(MinH), .MinL(MinL), .SecH(SecH), .SecL(SecL),
        .Running(Running), .Done(Done), .Expired(Expired)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time held as a plain number of seconds.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mst_t;
    mst_t m_st = M_IDLE;
    int   m_secs = 0, m_pre = 0, m_shadow = 0;
    bit   m_done = 1'b0;

    function automatic int clampd(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic logic [18:0] model_vec();
        int mins, ss;
        mins = m_secs / 60;
        ss   = m_secs % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(ss / 10), 4'(ss % 10),
                m_st == M_RUN, m_done, m_st == M_EXP};
    endfunction

    initial forever begin
        @(posedge clk);
        if (CR) begin
            m_secs = 0; m_st = M_IDLE; m_pre = 0; m_done = 1'b0; m_shadow = 0;
        end else if (Load) begin
            m_secs = clampd(int'(LdMin[7:4]), 5) * 600 + clampd(int'(LdMin[3:0]), 9) * 60
                   + clampd(int'(LdSec[7:4]), 5) * 10 + clampd(int'(LdSec[3:0]), 9);
            m_shadow = m_secs; m_st = M_IDLE; m_pre = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_st)
                M_IDLE: if (EN && m_secs != 0) begin m_st = M_RUN; m_pre = 0; end
                M_RUN: begin
                    if (RELOAD && m_secs == 0) begin
                        m_secs = m_shadow; m_pre = 0;
                        if (!EN) m_st = M_PAUSE;
                    end else if (!EN) begin
                        m_st = M_PAUSE;
                    end else if (m_pre == TICK_DIV - 1) begin
                        m_pre = 0;
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_done = 1'b1;
                            if (!RELOAD) m_st = M_EXP;
                        end
                    end else begin
                        m_pre = m_pre + 1;
                    end
                end
                M_PAUSE: if (EN) m_st = M_RUN;
                default: m_st = m_st;
            endcase
        end
    end

    int          n_checks = 0, n_fail = 0;
    logic        pin_valid = 1'b0;
    logic [18:0] pin_exp = '0;
    string       pin_name = "";

    initial forever begin
        logic [18:0] got, want;
        @(negedge clk);
        got  = {MinH, MinL, SecH, SecL, Running, Done, Expired};
        want = model_vec();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL cycle t=%0t dut {mm:ss,run,done,exp}=%h expected=%h", $time, got, want);
        end
        if (pin_valid) begin
            n_checks++;
            if (want !== pin_exp) begin
                n_fail++;
                $display("FAIL pin_%0s model=%h expected=%h", pin_name, want, pin_exp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Checks the outputs produced by the next clock edge with the inputs currently applied.
    task automatic pin(input logic [15:0] d, input logic r, input logic dn, input logic e, input string nm);
        pin_exp   = {d, r, dn, e};
        pin_name  = nm;
        pin_valid = 1'b1;
        cyc(1);
        pin_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] m, input logic [7:0] s);
        LdMin = m; LdSec = s; Load = 1'b1;
        cyc(1);
        Load = 1'b0;
    endtask

    initial begin
        cyc(1);
        pin(16'h0000, 1'b0, 1'b0, 1'b0, "reset");
        CR = 1'b0; EN = 1'b1;
        pin(16'h0000, 1'b0, 1'b0, 1'b0, "idle_zero_en");
        cyc(8);
        pin(16'h0000, 1'b0, 1'b0, 1'b0, "idle_zero_hold");

        EN = 1'b0; load(8'h00, 8'h03);
        EN = 1'b1;
        pin(16'h0003, 1'b1, 1'b0, 1'b0, "run_start");
        cyc(3); pin(16'h0002, 1'b1, 1'b0, 1'b0, "dec_2");
        cyc(3); pin(16'h0001, 1'b1, 1'b0, 1'b0, "dec_1");
        cyc(3);
        if (RELOAD) begin
            pin(16'h0000, 1'b1, 1'b1, 1'b0, "zero_done_reload");
            pin(16'h0003, 1'b1, 1'b0, 1'b0, "reloaded_3");
        end else begin
            pin(16'h0000, 1'b0, 1'b1, 1'b1, "zero_done");
            pin(16'h0000, 1'b0, 1'b0, 1'b1, "expired_hold");
        end
        cyc(5);

        EN = 1'b0; load(8'h10, 8'h00);
        EN = 1'b1;
        pin(16'h1000, 1'b1, 1'b0, 1'b0, "run_10_00");
        cyc(3); pin(16'h0959, 1'b1, 1'b0, 1'b0, "borrow_09_59");
        load(8'h01, 8'h00);
        pin(16'h0100, 1'b1, 1'b0, 1'b0, "rerun_01_00");
        cyc(3); pin(16'h0059, 1'b1, 1'b0, 1'b0, "borrow_00_59");

        load(8'h00, 8'h05);
        cyc(6);
        EN = 1'b0;
        pin(16'h0004, 1'b0, 1'b0, 1'b0, "pause_enter");
        cyc(19);
        pin(16'h0004, 1'b0, 1'b0, 1'b0, "pause_hold");
        EN = 1'b1;
        pin(16'h0004, 1'b1, 1'b0, 1'b0, "resume");
        cyc(2);
        pin(16'h0003, 1'b1, 1'b0, 1'b0, "resume_dec");

        EN = 1'b0;
        LdMin = 8'h7A; LdSec = 8'h6F; Load = 1'b1;
        pin(16'h5959, 1'b0, 1'b0, 1'b0, "clamp_59_59");
        Load = 1'b0; EN = 1'b1;
        pin(16'h5959, 1'b1, 1'b0, 1'b0, "run_59_59");
        cyc(3);
        LdMin = 8'h00; LdSec = 8'h07; Load = 1'b1;
        pin(16'h0007, 1'b0, 1'b0, 1'b0, "load_on_tick");
        Load = 1'b0;
        pin(16'h0007, 1'b1, 1'b0, 1'b0, "rerun_after_load");

        if (RELOAD) begin
            EN = 1'b0; load(8'h00, 8'h02);
            EN = 1'b1;
            pin(16'h0002, 1'b1, 1'b0, 1'b0, "ar_start");
            cyc(3); pin(16'h0001, 1'b1, 1'b0, 1'b0, "ar_dec_1");
            cyc(3); pin(16'h0000, 1'b1, 1'b1, 1'b0, "ar_zero_done");
            pin(16'h0002, 1'b1, 1'b0, 1'b0, "ar_reloaded");
        end

        cyc(2);
        CR = 1'b1;
        pin(16'h0000, 1'b0, 1'b0, 1'b0, "reset_midrun");
        CR = 1'b0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
